// File: rtl/dcache_sram_nway.sv
// N-way set-associative data cache array with true-LRU replacement,
// byte-merging write hits, block fills and a single-entry dirty eviction buffer.
module dcache_sram_nway #(
  parameter int WAYS        = 4,
  parameter int SETS        = 2,
  parameter int TAG_W       = 3,
  parameter int BLOCK_BYTES = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ren,
  input  logic                          wen,
  input  logic                          memWen,
  input  logic [BLOCK_BYTES-1:0]        bytesAccess,
  input  logic [TAG_W+$clog2(SETS)-1:0] blockAddr,
  input  logic [8*BLOCK_BYTES-1:0]      dataIn,
  output logic                          hit,
  output logic                          dirtyBit,
  output logic [8*BLOCK_BYTES-1:0]      dataOut,
  output logic                          fillReady,
  output logic                          evictValid,
  input  logic                          evictAck,
  output logic [TAG_W+$clog2(SETS)-1:0] evictAddr,
  output logic [8*BLOCK_BYTES-1:0]      evictData
);
  localparam int SET_W      = $clog2(SETS);
  localparam int AGE_W      = $clog2(WAYS);
  localparam int ADDR_W     = TAG_W + SET_W;
  localparam int BLOCK_BITS = 8 * BLOCK_BYTES;

  typedef logic [AGE_W-1:0] way_t;

  logic [WAYS-1:0]       validQ [SETS];
  logic [WAYS-1:0]       dirtyQ [SETS];
  way_t                  ageQ   [SETS][WAYS];
  logic [TAG_W-1:0]      tagQ   [SETS][WAYS];
  logic [BLOCK_BITS-1:0] dataQ  [SETS][WAYS];

  logic [SET_W-1:0] setIdx;
  logic [TAG_W-1:0] reqTag;
  logic [WAYS-1:0]  matchVec;
  way_t             hitWay, lruWay, freeWay, victim, fillWay, accessWay;
  logic             hasFree, present, readHit, writeHit, fillDo, evictNeed, touch;

  assign setIdx = blockAddr[SET_W-1:0];
  assign reqTag = blockAddr[ADDR_W-1:SET_W];

  always_comb begin
    matchVec = '0;
    hitWay   = '0;
    lruWay   = '0;
    freeWay  = '0;
    hasFree  = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (validQ[setIdx][w] && tagQ[setIdx][w] == reqTag) begin
        matchVec[w] = 1'b1;
        hitWay      = way_t'(w);
      end
      if (ageQ[setIdx][w] == way_t'(WAYS - 1)) lruWay = way_t'(w);
      if (!validQ[setIdx][w] && !hasFree) begin
        hasFree = 1'b1;
        freeWay = way_t'(w);
      end
    end
  end

  // memWen > wen > ren; a fill blocked by a pending eviction suppresses everything.
  assign present   = |matchVec;
  assign victim    = hasFree ? freeWay : lruWay;
  assign hit       = (ren | wen | memWen) & present;
  assign readHit   = hit & ren & ~wen & ~memWen;
  assign writeHit  = hit & wen & ~memWen;
  assign fillReady = ~(evictValid & ~evictAck);
  assign fillDo    = memWen & fillReady;
  assign fillWay   = present ? hitWay : victim;
  assign evictNeed = fillDo & ~present & validQ[setIdx][victim] & dirtyQ[setIdx][victim];
  assign touch     = fillDo | writeHit | readHit;
  assign accessWay = fillDo ? fillWay : hitWay;
  assign dataOut   = readHit ? dataQ[setIdx][hitWay] : '0;
  assign dirtyBit  = hit ? dirtyQ[setIdx][hitWay]
                         : (validQ[setIdx][victim] & dirtyQ[setIdx][victim]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        validQ[s] <= '0;
        dirtyQ[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) ageQ[s][w] <= way_t'(w);
      end
      evictValid <= 1'b0;
      evictAddr  <= '0;
      evictData  <= '0;
    end else begin
      if (fillDo) begin
        validQ[setIdx][fillWay] <= 1'b1;
        dirtyQ[setIdx][fillWay] <= 1'b0;
      end else if (writeHit) begin
        dirtyQ[setIdx][hitWay] <= 1'b1;
      end
      if (touch) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (way_t'(w) == accessWay)
            ageQ[setIdx][w] <= '0;
          else if (ageQ[setIdx][w] < ageQ[setIdx][accessWay])
            ageQ[setIdx][w] <= ageQ[setIdx][w] + way_t'(1);
        end
      end
      // A new eviction on the acking edge reloads the buffer instead of clearing it.
      if (evictNeed) begin
        evictValid <= 1'b1;
        evictAddr  <= {tagQ[setIdx][victim], setIdx};
        evictData  <= dataQ[setIdx][victim];
      end else if (evictAck) begin
        evictValid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fillDo) begin
      tagQ[setIdx][fillWay]  <= reqTag;
      dataQ[setIdx][fillWay] <= dataIn;
    end else if (writeHit) begin
      for (int unsigned b = 0; b < BLOCK_BYTES; b++)
        if (bytesAccess[b]) dataQ[setIdx][hitWay][8*b +: 8] <= dataIn[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_dcache_sram_nway.sv
// Table-driven bench for dcache_sram_nway at default parameters, with a
// scoreboard queue and hand-written reset sequences.
module tb_dcache_sram_nway;
  localparam logic [3:0]  NOP = 4'b0000, AK = 4'b0001, RD = 4'b0010, WR = 4'b0100, FL = 4'b1000;
  localparam logic [63:0] Z  = 64'h0;
  localparam logic [63:0] AF = 64'hAAAAAAAA_FFFFFFFF;

  typedef struct {
    logic        ren, wen, memWen, ack;
    logic [7:0]  be;
    logic [3:0]  addr;
    logic [63:0] data;
    logic        eHit, eDirty, eReady, eEv;
    logic [63:0] eOut;
    logic [3:0]  eEvAddr;
    logic [63:0] eEvData;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, ren, wen, memWen, evictAck;
  logic [7:0]  bytesAccess;
  logic [3:0]  blockAddr;
  logic [63:0] dataIn;
  logic        hit, dirtyBit, fillReady, evictValid;
  logic [63:0] dataOut, evictData;
  logic [3:0]  evictAddr;

  int   nCmp = 0;
  int   nBad = 0;
  vec_t tbl[$];
  vec_t sb[$];
  vec_t v, e;
  logic [3:0] postAddr [5];

  always #5 clk = ~clk;

  dcache_sram_nway #(.WAYS(4), .SETS(2), .TAG_W(3), .BLOCK_BYTES(8)) dut (
    .clk(clk), .rst(rst), .ren(ren), .wen(wen), .memWen(memWen),
    .bytesAccess(bytesAccess), .blockAddr(blockAddr), .dataIn(dataIn),
    .hit(hit), .dirtyBit(dirtyBit), .dataOut(dataOut), .fillReady(fillReady),
    .evictValid(evictValid), .evictAck(evictAck), .evictAddr(evictAddr), .evictData(evictData)
  );

  function automatic logic [63:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  // fl = {hit, dirtyBit, fillReady, evictValid after the edge}
  function automatic vec_t mk(input logic [3:0] op, input logic [7:0] be, input logic [3:0] a,
                              input logic [63:0] d, input logic [3:0] fl, input logic [63:0] eo,
                              input logic [3:0] ea = 4'h0, input logic [63:0] evd = 64'h0);
    vec_t r;
    {r.memWen, r.wen, r.ren, r.ack} = op;
    r.be = be; r.addr = a; r.data = d;
    {r.eHit, r.eDirty, r.eReady, r.eEv} = fl;
    r.eOut = eo; r.eEvAddr = ea; r.eEvData = evd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    ren = x.ren; wen = x.wen; memWen = x.memWen; evictAck = x.ack;
    bytesAccess = x.be; blockAddr = x.addr; dataIn = x.data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // main functional sequence, set 0
    tbl.push_back(mk(WR,    8'hF0, 4'b0000, rep(8'hAA), 4'b0010, Z));
    tbl.push_back(mk(RD,    8'h00, 4'b0000, Z,          4'b0010, Z));
    tbl.push_back(mk(FL,    8'h00, 4'b0000, rep(8'hFF), 4'b0010, Z));
    tbl.push_back(mk(WR,    8'hF0, 4'b0000, rep(8'hAA), 4'b1010, Z));
    tbl.push_back(mk(RD,    8'h00, 4'b0000, Z,          4'b1110, AF));
    tbl.push_back(mk(FL,    8'h00, 4'b0010, rep(8'h11), 4'b0010, Z));
    tbl.push_back(mk(FL,    8'h00, 4'b0100, rep(8'h22), 4'b0010, Z));
    tbl.push_back(mk(FL,    8'h00, 4'b1000, rep(8'h44), 4'b0010, Z));
    tbl.push_back(mk(RD,    8'h00, 4'b0000, Z,          4'b1110, AF));
    tbl.push_back(mk(RD,    8'h00, 4'b1110, Z,          4'b0010, Z));
    tbl.push_back(mk(FL,    8'h00, 4'b1110, rep(8'h77), 4'b0010, Z));
    tbl.push_back(mk(RD,    8'h00, 4'b0010, Z,          4'b0010, Z));
    tbl.push_back(mk(RD,    8'h00, 4'b0100, Z,          4'b1010, rep(8'h22)));
    tbl.push_back(mk(RD,    8'h00, 4'b1000, Z,          4'b1010, rep(8'h44)));
    tbl.push_back(mk(RD,    8'h00, 4'b1110, Z,          4'b1010, rep(8'h77)));
    tbl.push_back(mk(RD,    8'h00, 4'b1010, Z,          4'b0110, Z));
    tbl.push_back(mk(FL,    8'h00, 4'b1010, rep(8'h55), 4'b0111, Z, 4'b0000, AF));
    tbl.push_back(mk(FL,    8'h00, 4'b1100, rep(8'h66), 4'b0001, Z, 4'b0000, AF));
    tbl.push_back(mk(RD,    8'h00, 4'b1100, Z,          4'b0001, Z, 4'b0000, AF));
    tbl.push_back(mk(AK,    8'h00, 4'b0000, Z,          4'b0010, Z));
    tbl.push_back(mk(RD,    8'h00, 4'b1010, Z,          4'b1010, rep(8'h55)));
    tbl.push_back(mk(RD,    8'h00, 4'b0000, Z,          4'b0010, Z));
    tbl.push_back(mk(WR,    8'h01, 4'b0100, 64'h12,     4'b1010, Z));
    tbl.push_back(mk(WR,    8'h80, 4'b1000, 64'h34000000_00000000, 4'b1010, Z));
    tbl.push_back(mk(RD,    8'h00, 4'b1110, Z,          4'b1010, rep(8'h77)));
    tbl.push_back(mk(RD,    8'h00, 4'b1010, Z,          4'b1010, rep(8'h55)));
    tbl.push_back(mk(FL,    8'h00, 4'b0110, rep(8'h33), 4'b0111, Z, 4'b0100, 64'h22222222_22222212));
    tbl.push_back(mk(FL|AK, 8'h00, 4'b1100, rep(8'h66), 4'b0111, Z, 4'b1000, 64'h34444444_44444444));
    tbl.push_back(mk(AK,    8'h00, 4'b0000, Z,          4'b0010, Z));
    tbl.push_back(mk(AK,    8'h00, 4'b0000, Z,          4'b0010, Z));
    tbl.push_back(mk(RD,    8'h00, 4'b1100, Z,          4'b1010, rep(8'h66)));
    tbl.push_back(mk(WR,    8'hFF, 4'b0110, rep(8'hAB), 4'b1010, Z));
    tbl.push_back(mk(RD,    8'h00, 4'b0110, Z,          4'b1110, rep(8'hAB)));
    tbl.push_back(mk(FL|WR, 8'h0F, 4'b0110, rep(8'hC0), 4'b1110, Z));
    tbl.push_back(mk(RD,    8'h00, 4'b0110, Z,          4'b1010, rep(8'hC0)));
    // set 1 traffic, then set 0 recheck
    tbl.push_back(mk(FL,    8'h00, 4'b0001, rep(8'h01), 4'b0010, Z));
    tbl.push_back(mk(FL,    8'h00, 4'b0011, rep(8'h02), 4'b0010, Z));
    tbl.push_back(mk(FL,    8'h00, 4'b0101, rep(8'h03), 4'b0010, Z));
    tbl.push_back(mk(FL,    8'h00, 4'b0111, rep(8'h04), 4'b0010, Z));
    tbl.push_back(mk(WR,    8'hFF, 4'b0001, rep(8'hEE), 4'b1010, Z));
    tbl.push_back(mk(RD,    8'h00, 4'b0011, Z,          4'b1010, rep(8'h02)));
    tbl.push_back(mk(RD,    8'h00, 4'b0101, Z,          4'b1010, rep(8'h03)));
    tbl.push_back(mk(RD,    8'h00, 4'b0111, Z,          4'b1010, rep(8'h04)));
    tbl.push_back(mk(RD,    8'h00, 4'b1001, Z,          4'b0110, Z));
    tbl.push_back(mk(FL,    8'h00, 4'b1001, rep(8'h05), 4'b0111, Z, 4'b0001, rep(8'hEE)));
    tbl.push_back(mk(AK,    8'h00, 4'b0000, Z,          4'b0010, Z));
    tbl.push_back(mk(RD,    8'h00, 4'b0000, Z,          4'b0010, Z));
    tbl.push_back(mk(FL,    8'h00, 4'b1000, rep(8'h48), 4'b0010, Z));
    tbl.push_back(mk(RD,    8'h00, 4'b1110, Z,          4'b0010, Z));
    tbl.push_back(mk(RD,    8'h00, 4'b1010, Z,          4'b1010, rep(8'h55)));
    tbl.push_back(mk(RD,    8'h00, 4'b0110, Z,          4'b1010, rep(8'hC0)));
    tbl.push_back(mk(RD,    8'h00, 4'b1100, Z,          4'b1010, rep(8'h66)));
    tbl.push_back(mk(RD,    8'h00, 4'b1000, Z,          4'b1010, rep(8'h48)));
    tbl.push_back(mk(RD,    8'h00, 4'b1001, Z,          4'b1010, rep(8'h05)));
    // leave a dirty eviction pending in set 1
    tbl.push_back(mk(WR,    8'hFF, 4'b0011, rep(8'h99), 4'b1010, Z));
    tbl.push_back(mk(RD,    8'h00, 4'b0101, Z,          4'b1010, rep(8'h03)));
    tbl.push_back(mk(RD,    8'h00, 4'b0111, Z,          4'b1010, rep(8'h04)));
    tbl.push_back(mk(RD,    8'h00, 4'b1001, Z,          4'b1010, rep(8'h05)));
    tbl.push_back(mk(RD,    8'h00, 4'b1101, Z,          4'b0110, Z));
    tbl.push_back(mk(FL,    8'h00, 4'b1101, rep(8'h61), 4'b0111, Z, 4'b0011, rep(8'h99)));

    rst = 1'b0;
    drive(mk(RD, 8'h00, 4'b0000, Z, 4'b0000, Z));
    #12;
    chk("rst.hit", 64'(hit), 64'h0);
    chk("rst.dataOut", dataOut, Z);
    chk("rst.dirtyBit", 64'(dirtyBit), 64'h0);
    chk("rst.fillReady", 64'(fillReady), 64'h1);
    chk("rst.evictValid", 64'(evictValid), 64'h0);
    chk("rst.evictAddr", 64'(evictAddr), 64'h0);
    chk("rst.evictData", evictData, Z);
    @(negedge clk);
    drive(mk(NOP, 8'h00, 4'b0000, Z, 4'b0000, Z));
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v);
      sb.push_back(v);
      #2;
      e = sb[0];
      chk($sformatf("v%0d.hit", i), 64'(hit), 64'(e.eHit));
      chk($sformatf("v%0d.dirtyBit", i), 64'(dirtyBit), 64'(e.eDirty));
      chk($sformatf("v%0d.dataOut", i), dataOut, e.eOut);
      chk($sformatf("v%0d.fillReady", i), 64'(fillReady), 64'(e.eReady));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d.evictValid", i), 64'(evictValid), 64'(e.eEv));
      if (e.eEv) begin
        chk($sformatf("v%0d.evictAddr", i), 64'(evictAddr), 64'(e.eEvAddr));
        chk($sformatf("v%0d.evictData", i), evictData, e.eEvData);
      end
      @(negedge clk);
    end

    // asynchronous reset while an eviction is pending
    drive(mk(RD, 8'h00, 4'b1101, Z, 4'b0000, Z));
    #1;
    chk("mid.preHit", 64'(hit), 64'h1);
    chk("mid.preData", dataOut, rep(8'h61));
    chk("mid.preReady", 64'(fillReady), 64'h0);
    rst = 1'b0;
    #1;
    chk("mid.evictValid", 64'(evictValid), 64'h0);
    chk("mid.evictAddr", 64'(evictAddr), 64'h0);
    chk("mid.evictData", evictData, Z);
    chk("mid.hit", 64'(hit), 64'h0);
    chk("mid.dataOut", dataOut, Z);
    chk("mid.dirtyBit", 64'(dirtyBit), 64'h0);
    chk("mid.fillReady", 64'(fillReady), 64'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    postAddr[0] = 4'b1101; postAddr[1] = 4'b0101; postAddr[2] = 4'b1010;
    postAddr[3] = 4'b0110; postAddr[4] = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      drive(mk(RD, 8'h00, postAddr[i], Z, 4'b0000, Z));
      #2;
      chk($sformatf("post%0d.hit", i), 64'(hit), 64'h0);
      chk($sformatf("post%0d.dataOut", i), dataOut, Z);
      chk($sformatf("post%0d.fillReady", i), 64'(fillReady), 64'h1);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule

// File: doc/dcache_sram_nway.md
DCACHE_SRAM_NWAY -- requirements
Module: dcache_sram_nway

Interface
REQ-001 SHALL provide parameter WAYS, default 4, associativity; power of two, 2..8.
REQ-002 SHALL provide parameter SETS, default 2, set count; power of two >= 2; SET_W = log2(SETS).
REQ-003 SHALL provide parameter TAG_W, default 3, tag width.
REQ-004 SHALL provide parameter BLOCK_BYTES, default 8, block size in bytes; BLOCK_BITS = 8*BLOCK_BYTES.
REQ-005 SHALL provide port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL provide port rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL provide ports ren/wen/memWen  in  1 each  CPU read, CPU byte write, memory block fill.
REQ-008 SHALL provide port bytesAccess  in  BLOCK_BYTES  byte enables for wen; bit i covers dataIn[8i+7:8i].
REQ-009 SHALL provide port blockAddr  in  TAG_W+SET_W  {tag, set}.
REQ-010 SHALL provide port dataIn  in  BLOCK_BITS  write/fill data.
REQ-011 SHALL provide ports hit, dirtyBit  out  1 each; dataOut  out  BLOCK_BITS.
REQ-012 SHALL provide ports fillReady  out  1; evictValid  out  1; evictAck  in  1; evictAddr  out  TAG_W+SET_W; evictData  out  BLOCK_BITS.

Function
REQ-013 hit SHALL be combinational: 1 when any valid way in set blockAddr[SET_W-1:0] has matching tag and (ren|wen|memWen)=1; else 0.
REQ-014 dataOut SHALL be combinational hit-way data on read hit, else 0.
REQ-015 dirtyBit SHALL be hit-way dirty on hit, victim-way dirty (valid&dirty) on miss.
REQ-016 Priority SHALL be memWen > wen > ren; only the highest asserted operation updates state.
REQ-017 Write hit SHALL merge enabled bytes only, set dirty=1, same edge.
REQ-018 Write miss SHALL change no state (no allocate); hit=0.
REQ-019 Read miss SHALL change no state except none; hit=0, dataOut=0.
REQ-020 Fill, address absent: victim = lowest-index invalid way, else way with age WAYS-1; write block, tag, valid=1, dirty=0.
REQ-021 Fill, address present: overwrite hit way, dirty=0, no eviction.
REQ-022 Fill into valid dirty victim SHALL load {victim tag, set}, victim data into eviction buffer and set evictValid=1 next edge.
REQ-023 evictValid SHALL hold, with evictAddr/evictData stable, until a rising edge sampling evictAck=1; then clear.
REQ-024 fillReady SHALL be 0 while evictValid=1 and evictAck=0; memWen while fillReady=0 SHALL be ignored entirely.
REQ-025 evictAck with evictValid=0 SHALL be ignored; same-edge ack plus new dirty eviction SHALL reload buffer, evictValid stays 1.
REQ-026 Replacement SHALL be true LRU: per-set age per way (log2 WAYS bits), ages form a permutation of 0..WAYS-1.
REQ-027 On read hit, write hit, or fill, accessed way age SHALL become 0; ways with smaller age increment; others unchanged.
REQ-028 Misses and ignored fills SHALL NOT alter ages.

Reset
REQ-029 While rst=0: all valid=0, dirty=0, way w age=w in every set, evictValid=0, evictAddr=0, evictData=0; block data undefined.
REQ-030 Reset mid-eviction SHALL discard buffer; fillReady=1 after reset.
REQ-031 Combinational outputs SHALL reflect cleared state during reset (hit=0, dataOut=0, dirtyBit=0).

Verification (defaults: WAYS=4, SETS=2, TAG_W=3, BLOCK_BYTES=8)
REQ-032 Write 0xAA.. bytes 7:4 to {000,0} after reset -> hit=0, state unchanged; fill all-ones; same write -> hit=1, dirtyBit=1; read -> dataOut=0xAAAAAAAA_FFFFFFFF.
REQ-033 Fill tags 001,010,100 in set 0 after above; read tag 000 -> hit=1; read miss tag 111 -> dirtyBit=0 (LRU victim tag 001 clean); fill 111 -> evictValid stays 0, tag 001 then misses.
REQ-034 Make tag 000 LRU and dirty, fill tag 101 -> evictValid=1, evictAddr={000,0}, evictData=old block, fillReady=0; second fill ignored; evictAck -> evictValid=0, fillReady=1.
REQ-035 Assert memWen and wen together on resident address -> fill wins, dirty=0, byte write lost.
REQ-036 Assert rst low with evictValid=1 -> evictValid=0 immediately, all reads miss afterward.
REQ-037 Set 1 accesses SHALL never disturb set 0 contents or ages (fill 4 tags in set 1, recheck set 0 hits).
